// File: rtl/seg_display_sched.sv
// seg_display_sched: round-robin time-slicing of datapath values onto the
// seven-segment display, plus ledclk scan generation. DISP_STEP_EN adds i_step.
module seg_display_sched #(
  parameter int  NSRC     = 4,
  parameter int  SCAN_DIV = 25000,
  parameter int  DWELL    = 64,
  localparam int SW       = $clog2(NSRC)
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic [16*NSRC-1:0]   i_src_data,
  input  logic [NSRC-1:0]      i_src_req,
`ifdef DISP_STEP_EN
  input  logic                 i_step,
`endif
  output logic [15:0]          o_show_data,
  output logic                 o_ledclk,
  output logic [SW-1:0]        o_cur_src,
  output logic [NSRC-1:0]      o_grant,
  output logic                 o_busy
);

  typedef enum logic {ST_IDLE, ST_SHOW} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [15:0]     r_div_cnt;
  logic            r_ledclk;
  logic [1:0]      r_scan_cnt;
  logic [7:0]      r_dwell_cnt;
  logic [15:0]     r_show_data;
  logic [SW-1:0]   r_cur_src;
  logic [NSRC-1:0] r_grant;

  logic            w_wrap;
  logic            w_frame_tick;
  logic            w_dwell_done;
  logic            w_step;
  logic            w_found;
  logic            w_load;
  logic [SW-1:0]   w_sel;
  logic [15:0]     w_slices [NSRC];
  logic [NSRC-1:0] w_onehot;

`ifdef DISP_STEP_EN
  assign w_step = i_step;
`else
  assign w_step = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
      assign w_slices[gi] = i_src_data[16*gi +: 16];
      assign w_onehot[gi] = (w_sel == SW'(gi));
    end
  endgenerate

  // Scan divider: free-running in every state, only reset clears it.
  assign w_wrap       = (r_div_cnt == 16'(SCAN_DIV - 1));
  assign w_frame_tick = w_wrap && !r_ledclk && (r_scan_cnt == 2'd3);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_div_cnt  <= '0;
      r_ledclk   <= 1'b0;
      r_scan_cnt <= '0;
    end else if (w_wrap) begin
      r_div_cnt <= '0;
      r_ledclk  <= !r_ledclk;
      if (!r_ledclk) begin
        r_scan_cnt <= r_scan_cnt + 2'd1;
      end
    end else begin
      r_div_cnt <= r_div_cnt + 16'd1;
    end
  end

  // Round-robin: smallest distance from cur_src+1 wins.
  always_comb begin : arb
    int v_best;
    int v_dist;
    v_best  = NSRC;
    v_dist  = 0;
    w_sel   = r_cur_src;
    w_found = |i_src_req;
    for (int j = 0; j < NSRC; j++) begin
      v_dist = (j + NSRC - 1 - int'(r_cur_src)) % NSRC;
      if (i_src_req[j] && (v_dist < v_best)) begin
        v_best = v_dist;
        w_sel  = SW'(j);
      end
    end
  end

  assign w_dwell_done = w_frame_tick && (r_dwell_cnt == 8'(DWELL - 1));

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_load       = 1'b1;
          w_state_next = ST_SHOW;
        end
      end
      ST_SHOW: begin
        if (w_dwell_done || w_step) begin
          if (w_found) begin
            w_load = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_show_data <= '0;
      r_cur_src   <= SW'(NSRC - 1);
      r_grant     <= '0;
      r_dwell_cnt <= '0;
    end else begin
      r_grant <= '0;
      if (w_load) begin
        r_show_data <= w_slices[w_sel];
        r_cur_src   <= w_sel;
        r_grant     <= w_onehot;
        r_dwell_cnt <= '0;
      end else if ((r_state == ST_SHOW) && w_frame_tick) begin
        r_dwell_cnt <= r_dwell_cnt + 8'd1;
      end
    end
  end

  assign o_show_data = r_show_data;
  assign o_ledclk    = r_ledclk;
  assign o_cur_src   = r_cur_src;
  assign o_grant     = r_grant;
  assign o_busy      = (r_state == ST_SHOW);

endmodule
